// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared state type, blanking constants and anode decode for the display arbiter
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [7:0] BLANK_SEG_DEFAULT = 8'hFF;
    localparam logic [3:0] AN_OFF            = 4'b1111;

    function automatic logic [3:0] digit_to_an(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - digit slot counter for the shared display; SEG_BRIGHTNESS_PWM_EN adds subslot dimming
// digit/lit are next-cycle values so the top can register them alongside its own next state.
module digit_scanner #(
    parameter int SCAN_TICKS = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
`ifdef SEG_BRIGHTNESS_PWM_EN
    input  logic [3:0] dim,
`endif
    output logic [1:0] digit,
    output logic       lit
);

    localparam int CW = $clog2(SCAN_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (clear) begin
            cnt_d   = '0;
            digit_d = '0;
        end else if (run) begin
            if (cnt_q == CW'(SCAN_TICKS - 1)) begin
                cnt_d   = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    assign digit = digit_d;

`ifdef SEG_BRIGHTNESS_PWM_EN
    localparam int SUB_TICKS = SCAN_TICKS / 16;
    localparam int SW        = $clog2(SUB_TICKS + 1);

    logic [SW-1:0] sub_q, sub_d;
    logic [3:0]    subslot_q, subslot_d;
    logic [3:0]    dim_q, dim_d;

    // Sixteen subslots tile one digit slot exactly, so subslot wraps together with cnt.
    always_comb begin
        sub_d     = sub_q;
        subslot_d = subslot_q;
        if (clear) begin
            sub_d     = '0;
            subslot_d = '0;
        end else if (run) begin
            if (sub_q == SW'(SUB_TICKS - 1)) begin
                sub_d     = '0;
                subslot_d = subslot_q + 4'd1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
        dim_d = (cnt_d == '0) ? dim : dim_q;
        lit   = (subslot_d <= dim_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q     <= '0;
            subslot_q <= '0;
            dim_q     <= '0;
        end else begin
            sub_q     <= sub_d;
            subslot_q <= subslot_d;
            dim_q     <= dim_d;
        end
    end
`else
    assign lit = 1'b1;
`endif

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner of the 4-digit seven-segment display with hold and blanking gap
// Optional brightness dimming input dim is enabled by SEG_BRIGHTNESS_PWM_EN.
module seg_display_arbiter #(
    parameter int         SCAN_TICKS  = 100_000,
    parameter int         HOLD_TICKS  = 25_000_000,
    parameter int         BLANK_TICKS = 1_000,
    parameter logic [7:0] BLANK_SEG   = seg_disp_pkg::BLANK_SEG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] seg0,
    input  logic [31:0] seg1,
`ifdef SEG_BRIGHTNESS_PWM_EN
    input  logic [3:0]  dim,
`endif
    output logic [1:0]  grant,
    output logic [7:0]  led,
    output logic [3:0]  an
);

    import seg_disp_pkg::*;

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLANK_TICKS + 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [1:0]    grant_q, grant_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    led_q, led_d;

    logic          owner;
    logic          own_next;
    logic          entering;
    logic [1:0]    scan_digit;
    logic          scan_lit;
    logic [31:0]   seg_sel;

    assign owner    = (state_q == OWN1);
    assign own_next = (state_d == OWN0) || (state_d == OWN1);
    assign entering = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req == 2'b11)  state_d = last_q ? OWN0 : OWN1;
                else if (req[0])   state_d = OWN0;
                else if (req[1])   state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (!req[owner] || (hold_q == HW'(HOLD_TICKS - 1) && req[~owner])) begin
                    state_d = BLANK;
                    last_d  = owner;
                end
            end
            BLANK: begin
                if (blank_q == BW'(BLANK_TICKS - 1)) begin
                    if (req[~last_q])     state_d = last_q ? OWN0 : OWN1;
                    else if (req[last_q]) state_d = last_q ? OWN1 : OWN0;
                    else                  state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d  = '0;
        blank_d = '0;
        if (own_next && !entering)
            hold_d = (hold_q == HW'(HOLD_TICKS - 1)) ? hold_q : hold_q + HW'(1);
        if (state_d == BLANK && !entering)
            blank_d = blank_q + BW'(1);
    end

    digit_scanner #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_scanner (
        .clk   (clk),
        .reset (reset),
        .clear (own_next && entering),
        .run   (own_next),
`ifdef SEG_BRIGHTNESS_PWM_EN
        .dim   (dim),
`endif
        .digit (scan_digit),
        .lit   (scan_lit)
    );

    // Outputs are built from next state so grant and the lit digit land on the first owned cycle.
    always_comb begin
        seg_sel = (state_d == OWN1) ? seg1 : seg0;
        grant_d = {state_d == OWN1, state_d == OWN0};
        an_d    = AN_OFF;
        led_d   = BLANK_SEG;
        if (own_next && scan_lit) begin
            an_d  = digit_to_an(scan_digit);
            led_d = seg_sel[{scan_digit, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            blank_q <= '0;
            grant_q <= 2'b00;
            an_q    <= AN_OFF;
            led_q   <= BLANK_SEG;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            blank_q <= blank_d;
            grant_q <= grant_d;
            an_q    <= an_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign an    = an_q;
    assign led   = led_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - scoreboard bench for seg_display_arbiter; SEG_BRIGHTNESS_PWM_EN adds dim cases
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] seg0;
    logic [31:0] seg1;
`ifdef SEG_BRIGHTNESS_PWM_EN
    logic [3:0]  dim;
`endif
    logic [1:0]  grant;
    logic [7:0]  led;
    logic [3:0]  an;

    typedef struct {
        int         cyc;
        logic [1:0] grant;
        logic [3:0] an;
        logic [7:0] led;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    seg_display_arbiter #(
        .SCAN_TICKS  (16),
        .HOLD_TICKS  (40),
        .BLANK_TICKS (3),
        .BLANK_SEG   (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .seg0  (seg0),
        .seg1  (seg1),
`ifdef SEG_BRIGHTNESS_PWM_EN
        .dim   (dim),
`endif
        .grant (grant),
        .led   (led),
        .an    (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input logic [1:0] g, input logic [3:0] a,
                             input logic [7:0] l, input string name);
        exp_t e;
        e.cyc   = at;
        e.grant = g;
        e.an    = a;
        e.led   = l;
        e.name  = name;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            total++;
            if ($countones(an) < 3) begin
                bad++;
                $display("FAIL anode_onecold cyc=%0d got an=%b required at most one low", cyc, an);
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    total++;
                    if (sb[i].cyc != cyc || grant !== sb[i].grant || an !== sb[i].an || led !== sb[i].led) begin
                        bad++;
                        $display("FAIL %s cyc=%0d/%0d got grant=%b an=%b led=%h required grant=%b an=%b led=%h",
                                 sb[i].name, cyc, sb[i].cyc, grant, an, led, sb[i].grant, sb[i].an, sb[i].led);
                    end
                    sb.delete(i);
                end
            end
            if (done) begin
                total++;
                if (sb.size() != 0) begin
                    bad++;
                    $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        req   = 2'b00;
        seg0  = 32'h11223344;
        seg1  = 32'hAABBCCDD;
`ifdef SEG_BRIGHTNESS_PWM_EN
        dim   = 4'hF;
`endif
        step(3);
        expect_at(cyc, 2'b00, 4'b1111, 8'hFF, "reset_state");
        step(1);
        reset = 1'b0;
        step(2);

        // single owner scan with wrap
        t   = cyc;
        req = 2'b01;
        expect_at(t + 1,  2'b01, 4'b1110, 8'h44, "scan_d0_first");
        expect_at(t + 16, 2'b01, 4'b1110, 8'h44, "scan_d0_last");
        expect_at(t + 17, 2'b01, 4'b1101, 8'h33, "scan_d1");
        expect_at(t + 33, 2'b01, 4'b1011, 8'h22, "scan_d2");
        expect_at(t + 49, 2'b01, 4'b0111, 8'h11, "scan_d3");
        expect_at(t + 64, 2'b01, 4'b0111, 8'h11, "scan_d3_last");
        expect_at(t + 65, 2'b01, 4'b1110, 8'h44, "scan_wrap");
        step(66);
        t   = cyc;
        req = 2'b00;
        expect_at(t + 1, 2'b00, 4'b1111, 8'hFF, "drop_blank");
        expect_at(t + 4, 2'b00, 4'b1111, 8'hFF, "drop_idle");
        step(6);

        // hold enforcement then voluntary release by requester 1
        t   = cyc;
        req = 2'b01;
        expect_at(t + 1, 2'b01, 4'b1110, 8'h44, "hold_entry");
        step(6);
        req = 2'b11;
        expect_at(t + 20, 2'b01, 4'b1101, 8'h33, "hold_mid");
        expect_at(t + 40, 2'b01, 4'b1011, 8'h22, "hold_last_own");
        expect_at(t + 41, 2'b00, 4'b1111, 8'hFF, "hold_blank1");
        expect_at(t + 43, 2'b00, 4'b1111, 8'hFF, "hold_blank3");
        expect_at(t + 44, 2'b10, 4'b1110, 8'hDD, "hold_handover");
        expect_at(t + 46, 2'b10, 4'b1110, 8'hDD, "rel_owner");
        step(40);
        req = 2'b00;
        expect_at(t + 47, 2'b00, 4'b1111, 8'hFF, "rel_blank1");
        expect_at(t + 49, 2'b00, 4'b1111, 8'hFF, "rel_blank3");
        expect_at(t + 50, 2'b00, 4'b1111, 8'hFF, "rel_idle");
        step(10);

        // round robin with both requesters held
        t   = cyc;
        req = 2'b11;
        expect_at(t + 1,   2'b01, 4'b1110, 8'h44, "rr_own0_a");
        expect_at(t + 40,  2'b01, 4'b1011, 8'h22, "rr_own0_end");
        expect_at(t + 41,  2'b00, 4'b1111, 8'hFF, "rr_blank_a");
        expect_at(t + 44,  2'b10, 4'b1110, 8'hDD, "rr_own1_a");
        expect_at(t + 83,  2'b10, 4'b1011, 8'hBB, "rr_own1_end");
        expect_at(t + 84,  2'b00, 4'b1111, 8'hFF, "rr_blank_b");
        expect_at(t + 87,  2'b01, 4'b1110, 8'h44, "rr_own0_b");
        expect_at(t + 130, 2'b10, 4'b1110, 8'hDD, "rr_own1_b");
        step(136);

        // async reset mid-scan, then requester 0 preferred
        t     = cyc;
        reset = 1'b1;
        expect_at(t,     2'b00, 4'b1111, 8'hFF, "rst_async");
        expect_at(t + 1, 2'b00, 4'b1111, 8'hFF, "rst_held");
        step(2);
        reset = 1'b0;
        expect_at(t + 3, 2'b01, 4'b1110, 8'h44, "rst_prefers0");
        step(2);
        seg0 = 32'h11223355;
        expect_at(t + 5, 2'b01, 4'b1110, 8'h55, "live_seg");
        step(2);
        req = 2'b00;
        step(6);
        seg0 = 32'h11223344;

        // one-cycle request glitch in IDLE
        t   = cyc;
        req = 2'b10;
        expect_at(t + 1, 2'b10, 4'b1110, 8'hDD, "glitch_grant");
        expect_at(t + 2, 2'b00, 4'b1111, 8'hFF, "glitch_blank");
        expect_at(t + 5, 2'b00, 4'b1111, 8'hFF, "glitch_idle");
        step(1);
        req = 2'b00;
        step(8);

`ifdef SEG_BRIGHTNESS_PWM_EN
        t   = cyc;
        dim = 4'd3;
        req = 2'b01;
        expect_at(t + 1,  2'b01, 4'b1110, 8'h44, "pwm_sub0");
        expect_at(t + 4,  2'b01, 4'b1110, 8'h44, "pwm_sub3");
        expect_at(t + 5,  2'b01, 4'b1111, 8'hFF, "pwm_sub4_dark");
        expect_at(t + 16, 2'b01, 4'b1111, 8'hFF, "pwm_sub15_dark");
        expect_at(t + 17, 2'b01, 4'b1101, 8'h33, "pwm_next_slot");
        step(20);
        dim = 4'hF;
        expect_at(t + 25, 2'b01, 4'b1111, 8'hFF, "pwm_dim_held");
        expect_at(t + 33, 2'b01, 4'b1011, 8'h22, "pwm_full_sub0");
        expect_at(t + 40, 2'b01, 4'b1011, 8'h22, "pwm_full_sub7");
        expect_at(t + 48, 2'b01, 4'b1011, 8'h22, "pwm_full_sub15");
        step(30);
        req = 2'b00;
        step(6);
`endif

        step(2);
        done = 1'b1;
    end

endmodule
